wb_port_arbiter: RTL

- Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency multiply/divide unit (MDU).
- Sits after the writeback-cycle result mux: pipeline result (ResultW/RdW/RegWriteW) and MDU result both enter, one write per cycle leaves to the register file.
- Holds one deferred MDU result, ages it, and requests a pipeline stall to guarantee the MDU is never starved.

---
 rtl/wb_pkg.sv | 8 +
 rtl/wb_port_arbiter_if.sv | 29 ++
 rtl/wb_pend_buf.sv | 41 ++++
 rtl/wb_port_arbiter.sv | 91 +++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package wb_pkg;
  localparam int XLEN_D   = 32;
  localparam int REG_AW_D = 5;
  localparam logic [REG_AW_D-1:0] X0 = '0;

  typedef enum logic [1:0] {IDLE, PEND, FORCE} wb_state_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback-side bus: pipeline and MDU results in, register-file write and status out.
interface wb_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) ();
  logic              RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic [XLEN-1:0]   ResultW;
  logic              mdu_valid;
  logic [REG_AW-1:0] mdu_rd;
  logic [XLEN-1:0]   mdu_data;
  logic              mdu_ready;
  logic              rf_we;
  logic [REG_AW-1:0] rf_addr;
  logic [XLEN-1:0]   rf_wdata;
  logic              stall_req;
  logic              pend_valid;
  logic [REG_AW-1:0] pend_rd;

  modport master (
    output RegWriteW, RdW, ResultW, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, rf_we, rf_addr, rf_wdata, stall_req, pend_valid, pend_rd
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, rf_we, rf_addr, rf_wdata, stall_req, pend_valid, pend_rd
  );
endinterface

// File: rtl/wb_pend_buf.sv
// Single-entry holding register for an MDU result that lost the write port,
// with a saturating age counter.
module wb_pend_buf #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              drain,
  input  logic [REG_AW-1:0] cap_rd,
  input  logic [XLEN-1:0]   cap_data,
  output logic              valid,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   data,
  output logic [WAIT_W-1:0] age
);
  localparam logic [WAIT_W-1:0] AGE_MAX = WAIT_W'(MAX_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
      age   <= '0;
    end else if (capture) begin
      // capture may coincide with a drain; the new entry starts fresh
      valid <= 1'b1;
      rd    <= cap_rd;
      data  <= cap_data;
      age   <= '0;
    end else if (drain) begin
      valid <= 1'b0;
      age   <= '0;
    end else if (valid && age != AGE_MAX) begin
      age <= age + 1'b1;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback stage and the MDU, deferring and aging one MDU result.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN     = XLEN_D,
  parameter int REG_AW   = REG_AW_D,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);
  localparam logic [WAIT_W-1:0] AGE_MAX = WAIT_W'(MAX_WAIT);

  logic              pipe_wr, drain, mdu_direct, capture, mdu_ready;
  logic              pend_v;
  logic [REG_AW-1:0] pend_rd;
  logic [XLEN-1:0]   pend_data;
  logic [WAIT_W-1:0] age;
  logic              stall_q;
  wb_state_e         state_q, state_d;

  // x0 pipeline writes never claim the port
  assign pipe_wr    = bus.RegWriteW && (bus.RdW != X0);
  assign drain      = pend_v && !pipe_wr;
  assign mdu_ready  = !pend_v || drain;
  assign mdu_direct = !pipe_wr && !pend_v;
  assign capture    = bus.mdu_valid && mdu_ready && !mdu_direct && (bus.mdu_rd != X0);

  wb_pend_buf #(
    .XLEN(XLEN), .REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)
  ) u_pend (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .drain    (drain),
    .cap_rd   (bus.mdu_rd),
    .cap_data (bus.mdu_data),
    .valid    (pend_v),
    .rd       (pend_rd),
    .data     (pend_data),
    .age      (age)
  );

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_addr  = '0;
    bus.rf_wdata = '0;
    if (pipe_wr) begin
      bus.rf_we    = 1'b1;
      bus.rf_addr  = bus.RdW;
      bus.rf_wdata = bus.ResultW;
    end else if (pend_v) begin
      bus.rf_we    = 1'b1;
      bus.rf_addr  = pend_rd;
      bus.rf_wdata = pend_data;
    end else if (bus.mdu_valid && bus.mdu_rd != X0) begin
      bus.rf_we    = 1'b1;
      bus.rf_addr  = bus.mdu_rd;
      bus.rf_wdata = bus.mdu_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (capture) state_d = PEND;
      PEND:  if (drain)   state_d = capture ? PEND : IDLE;
             else if (age == AGE_MAX) state_d = FORCE;
      FORCE: if (drain)   state_d = capture ? PEND : IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= (state_d == FORCE);
    end
  end

  assign bus.mdu_ready  = mdu_ready;
  assign bus.stall_req  = stall_q;
  assign bus.pend_valid = pend_v;
  assign bus.pend_rd    = pend_rd;
endmodule
